// File: rtl/mispredict_recovery_sequencer.sv
// Branch-mispredict recovery sequencer: flush ROB + freelist, rebuild the speculative map from
// the architectural map, then redirect fetch. Optional perf counters under RECOVERY_PERF_EN.
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module mispredict_recovery_sequencer #(
  parameter int RESTORE_WIDTH    = 8,
  parameter int ARCH_REGS        = `ARCH_REG_SZ,
  parameter int ROB_IDX_W        = 5,
  parameter int ADDR_W           = 32,
  parameter int PHYS_REG_SZ_R10K = 64,
  parameter int PHYS_TAG_W       = $clog2(PHYS_REG_SZ_R10K),
  parameter int REG_IDX_W        = $clog2(ARCH_REGS)
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         mispredict_i,
  input  logic [ROB_IDX_W-1:0]                         mispred_rob_idx_i,
  input  logic [ADDR_W-1:0]                            branch_target_i,
  input  logic [PHYS_REG_SZ_R10K-1:0]                  freelist_restore_mask_i,
  input  logic [ARCH_REGS-1:0][PHYS_TAG_W-1:0]         arch_table_i,
  output logic                                         stall_o,
  output logic                                         rob_flush_o,
  output logic [ROB_IDX_W-1:0]                         rob_flush_idx_o,
  output logic                                         fl_restore_valid_o,
  output logic [PHYS_REG_SZ_R10K-1:0]                  fl_restore_mask_o,
  output logic [RESTORE_WIDTH-1:0]                     map_wr_en_o,
  output logic [RESTORE_WIDTH-1:0][REG_IDX_W-1:0]      map_wr_addr_o,
  output logic [RESTORE_WIDTH-1:0][PHYS_TAG_W-1:0]     map_wr_tag_o,
  output logic                                         fetch_redirect_o,
  output logic [ADDR_W-1:0]                            fetch_target_o,
  input  logic                                         fetch_redirect_ack_i,
  output logic                                         busy_o,
`ifdef RECOVERY_PERF_EN
  output logic [31:0]                                  perf_recoveries_o,
  output logic [31:0]                                  perf_stall_cycles_o,
`endif
  output logic                                         overlap_err_o
);

  localparam int PTR_W = $clog2(ARCH_REGS) + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_RESTORE  = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t                                     r_state;
  logic [PTR_W-1:0]                           r_ptr;
  logic [ADDR_W-1:0]                          r_target;
  logic                                       r_stall;
  logic                                       r_busy;
  logic                                       r_rob_flush;
  logic [ROB_IDX_W-1:0]                       r_rob_flush_idx;
  logic                                       r_fl_valid;
  logic [PHYS_REG_SZ_R10K-1:0]                r_fl_mask;
  logic [RESTORE_WIDTH-1:0]                   r_map_wr_en;
  logic [RESTORE_WIDTH-1:0][REG_IDX_W-1:0]    r_map_wr_addr;
  logic [RESTORE_WIDTH-1:0][PHYS_TAG_W-1:0]   r_map_wr_tag;
  logic                                       r_fetch_redirect;
  logic [ADDR_W-1:0]                          r_fetch_target;
  logic                                       r_overlap_err;

  logic [PTR_W-1:0]                           w_next_base;
  logic                                       w_last;
  logic [RESTORE_WIDTH-1:0][REG_IDX_W-1:0]    w_lane_addr;
  logic [RESTORE_WIDTH-1:0][PHYS_TAG_W-1:0]   w_lane_tag;

  // Lanes for the chunk presented next cycle: base 0 out of FLUSH, ptr+RESTORE_WIDTH out of RESTORE.
  always_comb begin
    if (r_state == S_RESTORE) begin
      w_next_base = r_ptr + PTR_W'(RESTORE_WIDTH);
    end else begin
      w_next_base = '0;
    end
    w_last = (r_ptr + PTR_W'(RESTORE_WIDTH)) == PTR_W'(ARCH_REGS);
    for (int i = 0; i < RESTORE_WIDTH; i++) begin
      w_lane_addr[i] = REG_IDX_W'(w_next_base + PTR_W'(i));
      w_lane_tag[i]  = arch_table_i[w_lane_addr[i]];
    end
  end

  // Recovery FSM; every output is loaded together with the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_ptr            <= '0;
      r_target         <= '0;
      r_stall          <= 1'b0;
      r_busy           <= 1'b0;
      r_rob_flush      <= 1'b0;
      r_rob_flush_idx  <= '0;
      r_fl_valid       <= 1'b0;
      r_fl_mask        <= '0;
      r_map_wr_en      <= '0;
      r_map_wr_addr    <= '0;
      r_map_wr_tag     <= '0;
      r_fetch_redirect <= 1'b0;
      r_fetch_target   <= '0;
      r_overlap_err    <= 1'b0;
    end else begin
      if ((r_state != S_IDLE) && mispredict_i) begin
        r_overlap_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (mispredict_i) begin
            r_state         <= S_FLUSH;
            r_target        <= branch_target_i;
            r_stall         <= 1'b1;
            r_busy          <= 1'b1;
            r_rob_flush     <= 1'b1;
            r_rob_flush_idx <= mispred_rob_idx_i;
            r_fl_valid      <= 1'b1;
            r_fl_mask       <= freelist_restore_mask_i;
          end
        end
        S_FLUSH: begin
          r_state         <= S_RESTORE;
          r_ptr           <= '0;
          r_rob_flush     <= 1'b0;
          r_rob_flush_idx <= '0;
          r_fl_valid      <= 1'b0;
          r_fl_mask       <= '0;
          r_map_wr_en     <= '1;
          r_map_wr_addr   <= w_lane_addr;
          r_map_wr_tag    <= w_lane_tag;
        end
        S_RESTORE: begin
          if (w_last) begin
            r_state          <= S_REDIRECT;
            r_map_wr_en      <= '0;
            r_map_wr_addr    <= '0;
            r_map_wr_tag     <= '0;
            r_fetch_redirect <= 1'b1;
            r_fetch_target   <= r_target;
          end else begin
            r_ptr         <= w_next_base;
            r_map_wr_addr <= w_lane_addr;
            r_map_wr_tag  <= w_lane_tag;
          end
        end
        S_REDIRECT: begin
          if (fetch_redirect_ack_i) begin
            r_state          <= S_IDLE;
            r_stall          <= 1'b0;
            r_busy           <= 1'b0;
            r_fetch_redirect <= 1'b0;
            r_fetch_target   <= '0;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_stall          <= 1'b0;
          r_busy           <= 1'b0;
          r_rob_flush      <= 1'b0;
          r_fl_valid       <= 1'b0;
          r_map_wr_en      <= '0;
          r_fetch_redirect <= 1'b0;
        end
      endcase
    end
  end

`ifdef RECOVERY_PERF_EN
  logic [31:0] r_perf_recoveries;
  logic [31:0] r_perf_stall_cycles;

  // Saturating recovery and stall-cycle counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_recoveries   <= 32'd0;
      r_perf_stall_cycles <= 32'd0;
    end else begin
      if ((r_state == S_IDLE) && mispredict_i && (r_perf_recoveries != 32'hFFFF_FFFF)) begin
        r_perf_recoveries <= r_perf_recoveries + 32'd1;
      end
      if (r_stall && (r_perf_stall_cycles != 32'hFFFF_FFFF)) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
    end
  end

  assign perf_recoveries_o   = r_perf_recoveries;
  assign perf_stall_cycles_o = r_perf_stall_cycles;
`endif

  assign stall_o            = r_stall;
  assign busy_o             = r_busy;
  assign rob_flush_o        = r_rob_flush;
  assign rob_flush_idx_o    = r_rob_flush_idx;
  assign fl_restore_valid_o = r_fl_valid;
  assign fl_restore_mask_o  = r_fl_mask;
  assign map_wr_en_o        = r_map_wr_en;
  assign map_wr_addr_o      = r_map_wr_addr;
  assign map_wr_tag_o       = r_map_wr_tag;
  assign fetch_redirect_o   = r_fetch_redirect;
  assign fetch_target_o     = r_fetch_target;
  assign overlap_err_o      = r_overlap_err;

endmodule

// File: tb/tb_mispredict_recovery_sequencer.sv
// Directed bench for mispredict_recovery_sequencer: a cycle-count model of the recovery
// timeline is compared against every output each cycle, plus literal spot checks.
module tb_mispredict_recovery_sequencer;

  localparam int RW   = 8;
  localparam int AR   = 32;
  localparam int ROBW = 5;
  localparam int AW   = 32;
  localparam int PR   = 64;
  localparam int TW   = 6;
  localparam int RIW  = 5;
  localparam int NCH  = AR / RW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                          reset;
  logic                          mispredict;
  logic [ROBW-1:0]               rob_idx;
  logic [AW-1:0]                 target;
  logic [PR-1:0]                 fl_mask;
  logic [AR-1:0][TW-1:0]         arch_table;
  logic                          ack;
  logic                          stall_o, rob_flush_o, fl_restore_valid_o, fetch_redirect_o;
  logic                          busy_o, overlap_err_o;
  logic [ROBW-1:0]               rob_flush_idx_o;
  logic [PR-1:0]                 fl_restore_mask_o;
  logic [RW-1:0]                 map_wr_en_o;
  logic [RW-1:0][RIW-1:0]        map_wr_addr_o;
  logic [RW-1:0][TW-1:0]         map_wr_tag_o;
  logic [AW-1:0]                 fetch_target_o;
`ifdef RECOVERY_PERF_EN
  logic [31:0]                   perf_recoveries_o, perf_stall_cycles_o;
`endif

  mispredict_recovery_sequencer #(.RESTORE_WIDTH(RW), .ARCH_REGS(AR)) dut (
    .clock(clock), .reset(reset),
    .mispredict_i(mispredict), .mispred_rob_idx_i(rob_idx), .branch_target_i(target),
    .freelist_restore_mask_i(fl_mask), .arch_table_i(arch_table),
    .stall_o(stall_o), .rob_flush_o(rob_flush_o), .rob_flush_idx_o(rob_flush_idx_o),
    .fl_restore_valid_o(fl_restore_valid_o), .fl_restore_mask_o(fl_restore_mask_o),
    .map_wr_en_o(map_wr_en_o), .map_wr_addr_o(map_wr_addr_o), .map_wr_tag_o(map_wr_tag_o),
    .fetch_redirect_o(fetch_redirect_o), .fetch_target_o(fetch_target_o),
    .fetch_redirect_ack_i(ack), .busy_o(busy_o),
`ifdef RECOVERY_PERF_EN
    .perf_recoveries_o(perf_recoveries_o), .perf_stall_cycles_o(perf_stall_cycles_o),
`endif
    .overlap_err_o(overlap_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_k counts cycles since capture (0 = idle). 1 = flush, 2..NCH+1 = restore
  // chunk m_k-2, NCH+2 onward = redirect until ack.
  int              m_k = 0;
  logic [ROBW-1:0] m_rob = '0;
  logic [AW-1:0]   m_tgt = '0;
  logic [PR-1:0]   m_mask = '0;
  logic            m_err = 1'b0;
  longint          m_recov = 0;
  longint          m_stall = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_k = 0; m_rob = '0; m_tgt = '0; m_mask = '0; m_err = 1'b0; m_recov = 0; m_stall = 0;
    end else if (m_k == 0) begin
      if (mispredict) begin
        m_k = 1; m_rob = rob_idx; m_tgt = target; m_mask = fl_mask; m_recov++;
      end
    end else begin
      m_stall++;
      if (mispredict) m_err = 1'b1;
      if (m_k >= NCH + 2) begin
        if (ack) m_k = 0;
      end else begin
        m_k++;
      end
    end
  end

  logic chk_en = 1'b0;
  logic e_flush, e_rest, e_redir;
  int   e_base;

  always @(negedge clock) begin
    if (chk_en) begin
      e_flush = (m_k == 1);
      e_rest  = (m_k >= 2) && (m_k <= NCH + 1);
      e_redir = (m_k >= NCH + 2);
      e_base  = e_rest ? (m_k - 2) * RW : 0;
      check("stall", stall_o, m_k != 0);
      check("busy", busy_o, m_k != 0);
      check("rob_flush", rob_flush_o, e_flush);
      check("rob_flush_idx", rob_flush_idx_o, e_flush ? m_rob : '0);
      check("fl_valid", fl_restore_valid_o, e_flush);
      check("fl_mask", fl_restore_mask_o, e_flush ? m_mask : '0);
      check("map_wr_en", map_wr_en_o, e_rest ? 8'hFF : 8'h00);
      for (int i = 0; i < RW; i++) begin
        check("map_wr_addr", map_wr_addr_o[i], e_rest ? 64'(e_base + i) : 64'd0);
        check("map_wr_tag", map_wr_tag_o[i], e_rest ? 64'(arch_table[e_base + i]) : 64'd0);
      end
      check("fetch_redirect", fetch_redirect_o, e_redir);
      check("fetch_target", fetch_target_o, e_redir ? m_tgt : '0);
      check("overlap_err", overlap_err_o, m_err);
`ifdef RECOVERY_PERF_EN
      check("perf_recoveries", perf_recoveries_o, 64'(m_recov));
      check("perf_stall_cycles", perf_stall_cycles_o, 64'(m_stall));
`endif
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse(input logic [ROBW-1:0] idx, input logic [AW-1:0] tgt);
    mispredict = 1'b1; rob_idx = idx; target = tgt;
    tick();
    mispredict = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (stall_o && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_reached", stall_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mispredict = 1'b0; rob_idx = '0; target = '0; fl_mask = '0; ack = 1'b1;
    for (int k = 0; k < AR; k++) arch_table[k] = TW'(k + 32);
    chk_en = 1'b1;
    repeat (3) tick();
    check("reset_stall", stall_o, 1'b0);
    check("reset_overlap", overlap_err_o, 1'b0);
    reset = 1'b0;
    tick();

    // Basic recovery, tags k+32, mask echo
    fl_mask = 64'hFFFF0000_FFFF0000;
    pulse(5'd5, 32'h0000_1000);
    check("lit_flush", rob_flush_o, 1'b1);
    check("lit_flush_idx", rob_flush_idx_o, 64'd5);
    check("lit_fl_mask", fl_restore_mask_o, 64'hFFFF0000_FFFF0000);
    tick(); check("lit_addr0", map_wr_addr_o[0], 64'd0);  check("lit_tag0", map_wr_tag_o[0], 64'd32);
    tick(); check("lit_addr8", map_wr_addr_o[0], 64'd8);  check("lit_tag8", map_wr_tag_o[0], 64'd40);
    tick(); check("lit_addr16", map_wr_addr_o[0], 64'd16);
    tick(); check("lit_addr31", map_wr_addr_o[7], 64'd31); check("lit_tag31", map_wr_tag_o[7], 64'd63);
    tick(); check("lit_redirect", fetch_redirect_o, 1'b1); check("lit_target", fetch_target_o, 64'h1000);
    tick(); check("lit_idle_stall", stall_o, 1'b0);

    // Delayed ack: redirect held 4 cycles
    for (int k = 0; k < AR; k++) arch_table[k] = TW'(k * 5 + 3);
    fl_mask = 64'h0123_4567_89AB_CDEF;
    ack = 1'b0;
    pulse(5'd9, 32'h0000_2000);
    repeat (5) tick();
    for (int c = 0; c < 3; c++) begin
      check("lit_hold_redirect", fetch_redirect_o, 1'b1);
      check("lit_hold_target", fetch_target_o, 64'h2000);
      tick();
    end
    check("lit_hold_redirect4", fetch_redirect_o, 1'b1);
    ack = 1'b1;
    tick();
    check("lit_after_ack", fetch_redirect_o, 1'b0);
    check("lit_after_ack_stall", stall_o, 1'b0);

    // Overlapping mispredict during RESTORE
    for (int k = 0; k < AR; k++) arch_table[k] = TW'(63 - k);
    pulse(5'd17, 32'hDEAD_BEE0);
    tick();
    pulse(5'd3, 32'h0000_4444);
    check("lit_overlap_set", overlap_err_o, 1'b1);
    wait_idle(20);
    repeat (2) tick();
    check("lit_overlap_sticky", overlap_err_o, 1'b1);

    // Reset in RESTORE cycle 2, then a clean recovery
    pulse(5'd21, 32'h0000_3000);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("lit_rst_stall", stall_o, 1'b0);
    check("lit_rst_wr_en", map_wr_en_o, 8'h00);
    check("lit_rst_overlap", overlap_err_o, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < AR; k++) arch_table[k] = TW'((k * 7 + 11) % 64);
    pulse(5'd7, 32'h0000_5000);
    check("lit_fresh_flush_idx", rob_flush_idx_o, 64'd7);
    wait_idle(20);

    // Back-to-back recoveries, second accepted on the first IDLE cycle
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    pulse(5'd1, 32'h0000_0100);
    wait_idle(20);
    pulse(5'd2, 32'h0000_0200);
    check("lit_b2b_flush", rob_flush_o, 1'b1);
    wait_idle(20);
    check("lit_b2b_overlap", overlap_err_o, 1'b0);
`ifdef RECOVERY_PERF_EN
    check("lit_perf_rec", perf_recoveries_o, 64'd2);
    check("lit_perf_stall", perf_stall_cycles_o, 64'd12);
`endif
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mispredict_recovery_sequencer.md
Name: mispredict_recovery_sequencer

Overview:
- Sequences pipeline recovery after retire detects a mispredicted branch.
- Captures the mispredict event and holds the front end and retire stalled.
- Flushes the ROB and restores the freelist, then rebuilds the speculative map table from the architectural map table over several cycles.
- Finally redirects fetch with a valid/ack handshake. Sits between the retire stage and the ROB, freelist, rename map table and fetch.

Parameters:
- RESTORE_WIDTH, 8, map-table entries rewritten per cycle; must be ≥1 and divide ARCH_REGS.
- ARCH_REGS, `ARCH_REG_SZ (32), number of architectural map entries to restore.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- mispredict_i  in  1  one-cycle mispredict pulse from retire
- mispred_rob_idx_i  in  ROB_IDX  ROB index of the mispredicted branch
- branch_target_i  in  ADDR  correct target of the branch
- freelist_restore_mask_i  in  PHYS_REG_SZ_R10K  freelist restore mask, valid with mispredict_i
- arch_table_i  in  MAP_ENTRY[ARCH_REGS]  live architectural map table
- stall_o  out  1  stall fetch/dispatch/retire; high in every state except IDLE
- rob_flush_o  out  1  ROB flush pulse
- rob_flush_idx_o  out  ROB_IDX  flush index; younger entries are flushed
- fl_restore_valid_o  out  1  freelist restore strobe
- fl_restore_mask_o  out  PHYS_REG_SZ_R10K  mask to load into the freelist
- map_wr_en_o  out  RESTORE_WIDTH  speculative map-table write enables
- map_wr_addr_o  out  REG_IDX[RESTORE_WIDTH]  write addresses
- map_wr_tag_o  out  PHYS_TAG[RESTORE_WIDTH]  write tags, taken from arch_table_i[addr]
- fetch_redirect_o  out  1  redirect request valid
- fetch_target_o  out  ADDR  redirect PC
- fetch_redirect_ack_i  in  1  fetch accepts the redirect
- busy_o  out  1  state != IDLE
- overlap_err_o  out  1  sticky: mispredict_i seen while not IDLE

Behaviour:
- Reset: state=IDLE; all outputs and captured registers are 0, including overlap_err_o.
- Reset mid-recovery aborts to IDLE next cycle with no further strobes.
- Capture: in IDLE, on mispredict_i the block registers mispred_rob_idx_i, branch_target_i and freelist_restore_mask_i, then goes to FLUSH.
- FLUSH (1 cycle):
  - rob_flush_o=1, rob_flush_idx_o=captured index.
  - fl_restore_valid_o=1, fl_restore_mask_o=captured mask.
  - Sets ptr=0 and goes to RESTORE.
- RESTORE (ARCH_REGS/RESTORE_WIDTH cycles):
  - For lane i: map_wr_en_o[i]=1, map_wr_addr_o[i]=ptr+i, map_wr_tag_o[i]=arch_table_i[ptr+i].phys.
  - ptr += RESTORE_WIDTH. When ptr+RESTORE_WIDTH==ARCH_REGS, go to REDIRECT.
  - arch_table_i is read live. It is stable because stall_o blocks retire.
  - ptr width is clog2(ARCH_REGS)+1 bits, so it never wraps.
- REDIRECT:
  - fetch_redirect_o=1 and fetch_target_o=captured target, held stable until fetch_redirect_ack_i.
  - Ack in the same cycle: go to IDLE next cycle. No ack: remain in REDIRECT.
- In IDLE, all strobes are 0 and stall_o=0. Register 0 is also rewritten with the table's value, with no special case.
- stall_o, busy_o and all strobes are registered state decodes.
- mispredict_i in the same cycle the block enters IDLE is accepted.
- mispredict_i in any non-IDLE state is ignored and sets overlap_err_o.
- Total recovery with immediate ack: 1 + ARCH_REGS/RESTORE_WIDTH + 1 cycles of stall_o.

Optional Feature:
- Macro: RECOVERY_PERF_EN.
- When defined:
  - Adds outputs perf_recoveries_o (32b) and perf_stall_cycles_o (32b).
  - perf_recoveries_o increments on each IDLE→FLUSH transition.
  - perf_stall_cycles_o increments each cycle stall_o=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Basic recovery, ARCH_REGS=32, RESTORE_WIDTH=8:
  - Stimulus: mispredict_i at cycle T with idx=5, target=0x1000, ack tied high.
  - Response: FLUSH at T+1 (rob_flush_idx_o=5); RESTORE at T+2..T+5 with addrs 0-7, 8-15, 16-23, 24-31; fetch_redirect_o at T+6 with target 0x1000; IDLE at T+7; stall_o high T+1..T+6.
- Delayed ack:
  - Stimulus: ack held 0 for 3 cycles in REDIRECT.
  - Response: fetch_redirect_o and target stable for 4 cycles, then IDLE.
- Tag correctness:
  - Stimulus: arch_table_i[k].phys=k+32.
  - Response: every map_wr_tag_o lane equals addr+32; freelist mask 0xFFFF0000_FFFF0000 echoed in FLUSH.
- Overlap:
  - Stimulus: second mispredict_i during RESTORE.
  - Response: ignored; overlap_err_o=1 and remains 1 until reset.
- Reset mid-operation:
  - Stimulus: reset asserted in RESTORE cycle 2.
  - Response: next cycle all outputs 0 and state IDLE; a fresh mispredict then recovers normally.
- RECOVERY_PERF_EN:
  - Stimulus: two back-to-back recoveries with immediate ack.
  - Response: perf_recoveries_o=2, perf_stall_cycles_o=12.
